// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter (instruction fetch and load/store
// unit) in front of a single-outstanding memory port.
//
// Handshake: a requester raises req with a stable payload and holds both
// until it sees its gnt. gnt is combinational and marks the cycle in which
// the request is accepted. The memory access runs with o_mem_req high and a
// frozen payload until i_mem_ack (or a timeout). The answer comes back as a
// one-cycle rvalid pulse with no back-pressure, and rerr flags a timeout.
module mem_arbiter #(
   parameter int STARVE_MAX = 4,    // LSU grants allowed while fetch waits, 1..15
   parameter int TIMEOUT    = 255   // cycles before an unacked access aborts, 2..255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   // fetch port
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_rvalid,
   output logic        o_if_rerr,
   output logic [31:0] o_if_rdata,
   // load/store port
   input  logic        i_ls_req,
   input  logic        i_ls_we,
   input  logic [31:0] i_ls_addr,
   input  logic [31:0] i_ls_wdata,
   input  logic [3:0]  i_ls_be,
   output logic        o_ls_gnt,
   output logic        o_ls_rvalid,
   output logic        o_ls_rerr,
   output logic [31:0] o_ls_rdata,
   // memory port
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_t;

   // Saturation point of the starvation counter and the last wait-counter
   // value before an access is abandoned.
   localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);
   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

   state_t     state;
   logic [3:0] starve_cnt;   // LSU grants given while fetch was waiting
   logic [7:0] wait_cnt;     // busy cycles elapsed without ack
   logic       if_win;
   logic       ls_win;

   // Arbitration: LSU first, unless fetch has been passed over STARVE_MAX
   // times. Grants exist only in IDLE and are held low during reset.
   always_comb begin
      if_win = 1'b0;
      ls_win = 1'b0;
      if (i_rst_n && (state == IDLE)) begin
         if (i_if_req && (!i_ls_req || (starve_cnt == STARVE_TOP))) begin
            if_win = 1'b1;
         end else if (i_ls_req) begin
            ls_win = 1'b1;
         end
      end
   end

   assign o_if_gnt = if_win;
   assign o_ls_gnt = ls_win;

   // Control FSM with registered memory-side and response outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         starve_cnt  <= 4'd0;
         wait_cnt    <= 8'd0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= 32'h0;
         o_mem_wdata <= 32'h0;
         o_mem_be    <= 4'h0;
         o_if_rvalid <= 1'b0;
         o_if_rerr   <= 1'b0;
         o_if_rdata  <= 32'h0;
         o_ls_rvalid <= 1'b0;
         o_ls_rerr   <= 1'b0;
         o_ls_rdata  <= 32'h0;
      end else begin
         // Response strobes are single-cycle pulses.
         o_if_rvalid <= 1'b0;
         o_if_rerr   <= 1'b0;
         o_ls_rvalid <= 1'b0;
         o_ls_rerr   <= 1'b0;

         case (state)
            IDLE: begin
               // Any i_mem_ack seen here belongs to nothing and is dropped.
               if (if_win) begin
                  state       <= BUSY_IF;
                  wait_cnt    <= 8'd0;
                  starve_cnt  <= 4'd0;
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= 1'b0;
                  o_mem_addr  <= i_if_addr;
                  o_mem_wdata <= 32'h0;
                  o_mem_be    <= 4'hF;
               end else if (ls_win) begin
                  state       <= BUSY_LS;
                  wait_cnt    <= 8'd0;
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= i_ls_we;
                  o_mem_addr  <= i_ls_addr;
                  o_mem_wdata <= i_ls_wdata;
                  o_mem_be    <= i_ls_be;
                  // Only grants that overtake a waiting fetch count.
                  if (i_if_req && (starve_cnt != STARVE_TOP)) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end

            BUSY_IF, BUSY_LS: begin
               if (i_mem_ack) begin
                  // Normal completion; an ack on the timeout cycle lands here.
                  if (state == BUSY_IF) begin
                     o_if_rvalid <= 1'b1;
                     o_if_rdata  <= i_mem_rdata;
                  end else begin
                     o_ls_rvalid <= 1'b1;
                     o_ls_rdata  <= o_mem_we ? 32'h0 : i_mem_rdata;
                  end
                  state       <= IDLE;
                  wait_cnt    <= 8'd0;
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_mem_addr  <= 32'h0;
                  o_mem_wdata <= 32'h0;
                  o_mem_be    <= 4'h0;
               end else if (wait_cnt == WAIT_LAST) begin
                  // Memory never answered: abandon and report an error.
                  if (state == BUSY_IF) begin
                     o_if_rvalid <= 1'b1;
                     o_if_rerr   <= 1'b1;
                     o_if_rdata  <= 32'h0;
                  end else begin
                     o_ls_rvalid <= 1'b1;
                     o_ls_rerr   <= 1'b1;
                     o_ls_rdata  <= 32'h0;
                  end
                  state       <= IDLE;
                  wait_cnt    <= 8'd0;
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_mem_addr  <= 32'h0;
                  o_mem_wdata <= 32'h0;
                  o_mem_be    <= 4'h0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            default: begin
               state     <= IDLE;
               o_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Invariant: never grant both requesters in one cycle.
   a_one_gnt: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_if_gnt && o_ls_gnt));

   // Invariant: grants only come out of IDLE.
   a_gnt_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (o_if_gnt || o_ls_gnt) |-> (state == IDLE));

   // Invariant: the memory request tracks the busy states exactly.
   a_req_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_mem_req == (state != IDLE));

   // Invariant: an error flag never appears without its response pulse.
   a_rerr_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (!o_if_rerr || o_if_rvalid) && (!o_ls_rerr || o_ls_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 8;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic        o_if_rerr;
   logic [31:0] o_if_rdata;
   logic        i_ls_req;
   logic        i_ls_we;
   logic [31:0] i_ls_addr;
   logic [31:0] i_ls_wdata;
   logic [3:0]  i_ls_be;
   logic        o_ls_gnt;
   logic        o_ls_rvalid;
   logic        o_ls_rerr;
   logic [31:0] o_ls_rdata;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .o_if_gnt    (o_if_gnt),
      .o_if_rvalid (o_if_rvalid),
      .o_if_rerr   (o_if_rerr),
      .o_if_rdata  (o_if_rdata),
      .i_ls_req    (i_ls_req),
      .i_ls_we     (i_ls_we),
      .i_ls_addr   (i_ls_addr),
      .i_ls_wdata  (i_ls_wdata),
      .i_ls_be     (i_ls_be),
      .o_ls_gnt    (o_ls_gnt),
      .o_ls_rvalid (o_ls_rvalid),
      .o_ls_rerr   (o_ls_rerr),
      .o_ls_rdata  (o_ls_rdata),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_be    (o_mem_be),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata)
   );

   // ---------------- clock ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;

   // Expected responses in grant order: {is_ls, err, rdata}.
   logic [33:0] exp_q[$];
   int          gnt_log[$];          // 1 = fetch grant, 2 = LSU grant

   // Reference model: one access in flight, described by its owner, the
   // busy cycle we are in and the busy cycle the memory will answer on.
   int          m_busy;              // 0 none, 1 fetch, 2 LSU
   int          m_idx;
   int          m_ack_at;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_pick;              // data the memory will return
   int          m_streak;            // fetch-overtaking LSU grants
   logic        m_rsp_pending;
   logic [31:0] m_if_last;
   logic [31:0] m_ls_last;

   // Requester and memory-responder knobs.
   logic        if_pend;
   logic        ls_pend;
   int          next_ack_at = 0;
   logic        next_rdata_en = 1'b0;
   logic [31:0] next_rdata = 32'h0;
   logic        fast_ack = 1'b0;
   int          idle_ack_pct = 25;
   int          mem_req_cycles;
   logic        saw_b2b;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_busy        = 0;
      m_idx         = 0;
      m_ack_at      = 0;
      m_streak      = 0;
      m_rsp_pending = 1'b0;
      m_if_last     = 32'h0;
      m_ls_last     = 32'h0;
      if_pend       = 1'b0;
      ls_pend       = 1'b0;
      exp_q.delete();
   endtask

   // Open a model transaction and predict its response.
   task automatic start_txn(input logic ls, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      m_busy  = ls ? 2 : 1;
      m_idx   = 1;
      m_we    = we;
      m_addr  = addr;
      m_wdata = wdata;
      m_be    = be;
      if (fast_ack) m_ack_at = 1;
      else if (next_ack_at != 0) m_ack_at = next_ack_at;
      else m_ack_at = int'($urandom_range(1, TIMEOUT + 2));
      next_ack_at = 0;
      m_pick = next_rdata_en ? next_rdata : $urandom;
      next_rdata_en = 1'b0;
      if (m_ack_at <= TIMEOUT) exp_q.push_back({ls, 1'b0, (we ? 32'h0 : m_pick)});
      else exp_q.push_back({ls, 1'b1, 32'h0});
   endtask

   task automatic issue_if(input logic [31:0] a);
      if_pend   = 1'b1;
      i_if_addr = a;
   endtask

   task automatic issue_ls(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
      ls_pend    = 1'b1;
      i_ls_we    = we;
      i_ls_addr  = a;
      i_ls_wdata = d;
      i_ls_be    = be;
   endtask

   // One clock cycle: drive after the rising edge, check and advance the
   // model on the falling edge.
   task automatic run_cycle(input int p_if, input int p_ls);
      logic        g_if;
      logic        g_ls;
      logic [33:0] e;
      @(posedge i_clk);
      #1;
      if (!if_pend && ($urandom_range(99) < p_if)) begin
         if_pend   = 1'b1;
         i_if_addr = $urandom;
      end
      if (!ls_pend && ($urandom_range(99) < p_ls)) begin
         ls_pend    = 1'b1;
         i_ls_we    = 1'($urandom_range(1));
         i_ls_addr  = $urandom;
         i_ls_wdata = $urandom;
         i_ls_be    = 4'($urandom);
      end
      i_if_req = if_pend;
      i_ls_req = ls_pend;
      if (m_busy != 0) begin
         i_mem_ack   = (m_idx == m_ack_at);
         i_mem_rdata = i_mem_ack ? m_pick : $urandom;
      end else begin
         i_mem_ack   = ($urandom_range(99) < idle_ack_pct);
         i_mem_rdata = $urandom;
      end

      @(negedge i_clk);
      g_if = (m_busy == 0) && if_pend && (!ls_pend || (m_streak == STARVE_MAX));
      g_ls = (m_busy == 0) && ls_pend && !g_if;
      check_eq("if_gnt", o_if_gnt, g_if);
      check_eq("ls_gnt", o_ls_gnt, g_ls);
      check_eq("mem_req", o_mem_req, m_busy != 0);
      check_eq("mem_we", o_mem_we, (m_busy != 0) ? m_we : 1'b0);
      check_eq("mem_addr", o_mem_addr, (m_busy != 0) ? m_addr : 32'h0);
      check_eq("mem_wdata", o_mem_wdata, (m_busy != 0) ? m_wdata : 32'h0);
      check_eq("mem_be", o_mem_be, (m_busy != 0) ? m_be : 4'h0);
      if (o_mem_req) mem_req_cycles++;
      if (o_ls_gnt && o_if_rvalid) saw_b2b = 1'b1;

      if (m_rsp_pending && (exp_q.size() == 0)) begin
         check_eq("rsp_queue_size", exp_q.size(), 1);
      end else if (m_rsp_pending) begin
         e = exp_q.pop_front();
         if (e[33]) m_ls_last = e[31:0];
         else m_if_last = e[31:0];
         check_eq("if_rvalid", o_if_rvalid, !e[33]);
         check_eq("ls_rvalid", o_ls_rvalid, e[33]);
         check_eq("if_rerr", o_if_rerr, !e[33] && e[32]);
         check_eq("ls_rerr", o_ls_rerr, e[33] && e[32]);
      end else begin
         check_eq("if_rvalid_idle", o_if_rvalid, 1'b0);
         check_eq("ls_rvalid_idle", o_ls_rvalid, 1'b0);
         check_eq("if_rerr_idle", o_if_rerr, 1'b0);
         check_eq("ls_rerr_idle", o_ls_rerr, 1'b0);
      end
      check_eq("if_rdata", o_if_rdata, m_if_last);
      check_eq("ls_rdata", o_ls_rdata, m_ls_last);

      // Advance the model to the next cycle.
      m_rsp_pending = 1'b0;
      if (m_busy != 0) begin
         if ((m_idx == m_ack_at) || (m_idx == TIMEOUT)) begin
            m_busy        = 0;
            m_rsp_pending = 1'b1;
         end else begin
            m_idx++;
         end
      end
      if (g_if) begin
         start_txn(1'b0, 1'b0, i_if_addr, 32'h0, 4'hF);
         m_streak = 0;
         if_pend  = 1'b0;
         gnt_log.push_back(1);
      end else if (g_ls) begin
         start_txn(1'b1, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be);
         if (if_pend && (m_streak < STARVE_MAX)) m_streak++;
         ls_pend = 1'b0;
         gnt_log.push_back(2);
      end
   endtask

   task automatic check_all_zero();
      check_eq("rst_if_gnt", o_if_gnt, 1'b0);
      check_eq("rst_ls_gnt", o_ls_gnt, 1'b0);
      check_eq("rst_rvalid", {o_if_rvalid, o_ls_rvalid}, 2'b00);
      check_eq("rst_rerr", {o_if_rerr, o_ls_rerr}, 2'b00);
      check_eq("rst_if_rdata", o_if_rdata, 32'h0);
      check_eq("rst_ls_rdata", o_ls_rdata, 32'h0);
      check_eq("rst_mem_ctl", {o_mem_req, o_mem_we, o_mem_be}, 6'h0);
      check_eq("rst_mem_addr", o_mem_addr, 32'h0);
      check_eq("rst_mem_wdata", o_mem_wdata, 32'h0);
   endtask

   // Asynchronous reset pulse, entered from just after a falling edge.
   task automatic pulse_reset();
      #2;
      i_rst_n   = 1'b0;
      i_if_req  = 1'b1;
      i_ls_req  = 1'b1;
      i_mem_ack = 1'b1;
      #1;
      check_all_zero();
      model_reset();
      @(negedge i_clk);
      i_if_req  = 1'b0;
      i_ls_req  = 1'b0;
      i_mem_ack = 1'b0;
      i_rst_n   = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int exp_order[6];
      i_rst_n     = 1'b0;
      i_if_req    = 1'b0;
      i_if_addr   = 32'h0;
      i_ls_req    = 1'b0;
      i_ls_we     = 1'b0;
      i_ls_addr   = 32'h0;
      i_ls_wdata  = 32'h0;
      i_ls_be     = 4'h0;
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'h0;
      model_reset();
      #1;
      check_all_zero();
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Single fetch, ack on the second busy cycle.
      issue_if(32'h0000_0010);
      next_ack_at   = 2;
      next_rdata    = 32'h0000_0013;
      next_rdata_en = 1'b1;
      mem_req_cycles = 0;
      repeat (4) run_cycle(0, 0);
      check_eq("fetch_rdata", o_if_rdata, 32'h0000_0013);
      check_eq("fetch_req_cycles", mem_req_cycles, 2);

      // LSU read to load a non-zero rdata, then a byte store.
      issue_ls(1'b0, 32'h0000_6000, 32'h0, 4'hF);
      next_ack_at   = 1;
      next_rdata    = 32'h0000_0055;
      next_rdata_en = 1'b1;
      repeat (3) run_cycle(0, 0);
      check_eq("ls_read_rdata", o_ls_rdata, 32'h0000_0055);
      issue_ls(1'b1, 32'h0000_7000, 32'h0000_00AB, 4'b0001);
      next_ack_at = 1;
      repeat (3) run_cycle(0, 0);
      check_eq("store_rdata", o_ls_rdata, 32'h0);

      // Timeout with no ack, then a normal follow-up.
      issue_ls(1'b0, 32'h0000_8000, 32'h0, 4'hF);
      next_ack_at    = 100;
      mem_req_cycles = 0;
      idle_ack_pct   = 0;
      repeat (TIMEOUT + 2) run_cycle(0, 0);
      check_eq("timeout_req_cycles", mem_req_cycles, TIMEOUT);
      idle_ack_pct = 25;
      issue_ls(1'b0, 32'h0000_8004, 32'h0, 4'hF);
      next_ack_at = 3;
      repeat (5) run_cycle(0, 0);

      // Ack exactly on the timeout cycle wins.
      issue_if(32'h0000_0100);
      next_ack_at = TIMEOUT;
      repeat (TIMEOUT + 2) run_cycle(0, 0);

      // Back-to-back: LSU granted in the fetch rvalid cycle.
      issue_if(32'h0000_0020);
      next_ack_at = 1;
      saw_b2b     = 1'b0;
      run_cycle(0, 0);
      issue_ls(1'b0, 32'h0000_9000, 32'h0, 4'hF);
      repeat (2) run_cycle(0, 0);
      check_eq("back_to_back", saw_b2b, 1'b1);
      repeat (TIMEOUT + 3) run_cycle(0, 0);

      // Reset mid-access: no response afterwards, even with acks around.
      issue_ls(1'b0, 32'h0000_A000, 32'h0, 4'hF);
      next_ack_at = 100;
      repeat (3) run_cycle(0, 0);
      pulse_reset();
      idle_ack_pct = 100;
      repeat (3) run_cycle(0, 0);
      idle_ack_pct = 25;
      issue_if(32'h0000_0044);
      repeat (TIMEOUT + 3) run_cycle(0, 0);

      // Starvation order with both requesters always asking.
      pulse_reset();
      gnt_log.delete();
      fast_ack = 1'b1;
      repeat (12) run_cycle(100, 100);
      fast_ack = 1'b0;
      exp_order = '{2, 2, 2, 2, 1, 2};
      check_eq("starve_len_ok", gnt_log.size() >= 6, 1'b1);
      if (gnt_log.size() >= 6) begin
         for (int i = 0; i < 6; i++) check_eq($sformatf("starve_order_%0d", i), gnt_log[i], exp_order[i]);
      end

      // Randomized traffic in three load profiles.
      repeat (300) run_cycle(90, 90);
      repeat (300) run_cycle(30, 60);
      repeat (300) run_cycle(10, 10);

      // Drain anything still pending.
      repeat (3 * (TIMEOUT + 3)) run_cycle(0, 0);
      check_eq("drain_queue", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive LSU grants allowed while a fetch request waits; range 1..15.
REQ-002 Parameter TIMEOUT, default 255: cycles a memory access may wait for i_mem_ack before it is aborted; range 2..255.
REQ-003 The block SHALL have one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-004 Ports, as name direction width meaning:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  async reset, active low
- i_if_req  in  1  fetch read request
- i_if_addr  in  32  fetch address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch response pulse
- o_if_rerr  out  1  fetch response is a timeout
- o_if_rdata  out  32  fetch read data
- i_ls_req  in  1  LSU request
- i_ls_we  in  1  LSU write
- i_ls_addr  in  32  LSU address
- i_ls_wdata  in  32  LSU store data
- i_ls_be  in  4  LSU byte enables
- o_ls_gnt  out  1  LSU request accepted this cycle
- o_ls_rvalid  out  1  LSU response pulse
- o_ls_rerr  out  1  LSU response is a timeout
- o_ls_rdata  out  32  LSU read data
- o_mem_req  out  1  memory access active
- o_mem_we  out  1  memory write
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory store data
- o_mem_be  out  4  memory byte enables
- i_mem_ack  in  1  memory completes the access this cycle
- i_mem_rdata  in  32  memory read data, valid with i_mem_ack

Function
REQ-005 The FSM SHALL have the states IDLE, BUSY_IF and BUSY_LS.
REQ-006 Grants SHALL be issued only in IDLE: o_x_gnt is combinational, high in the cycle of acceptance, and at most one gnt is high per cycle.
REQ-007 Arbitration SHALL give the LSU priority when both requests are high, except that fetch wins when starve_cnt == STARVE_MAX.
REQ-008 starve_cnt SHALL increment, saturating at STARVE_MAX, on an LSU grant while i_if_req is high, and SHALL clear on any fetch grant.
REQ-009 On a grant, the address, we, wdata and be SHALL be captured into registers (fetch: we=0, be=4'hF, wdata=0), and the FSM SHALL move to BUSY_IF or BUSY_LS.
REQ-010 In BUSY states, o_mem_req=1 and the o_mem_* outputs SHALL drive the captured values, held stable until the access completes or aborts; in IDLE, all o_mem_* outputs are 0.
REQ-011 On i_mem_ack in a BUSY state, o_x_rdata SHALL latch i_mem_rdata (0 for writes), o_x_rvalid SHALL pulse for exactly the next cycle with o_x_rerr=0, and the FSM SHALL return to IDLE.
REQ-012 A new grant SHALL be possible in the same cycle that rvalid is high; the minimum transaction spacing is 2 cycles.
REQ-013 A wait counter SHALL clear on entry to a BUSY state and increment each BUSY cycle without ack.
REQ-014 When the wait counter reaches TIMEOUT-1 without ack, the access SHALL abort: o_mem_req drops, the FSM goes to IDLE, and the next cycle carries o_x_rvalid=1, o_x_rerr=1 and o_x_rdata=32'h0.
REQ-015 An ack in the same cycle as the timeout SHALL win: the response is a normal one.
REQ-016 i_mem_ack SHALL be ignored in IDLE.
REQ-017 Requester signals SHALL be ignored while BUSY; a requester holds req until it sees its gnt.
REQ-018 o_x_rdata SHALL hold its last value between responses.

Reset
REQ-019 Asserting i_rst_n low SHALL immediately force state IDLE, starve_cnt=0, wait counter=0, all gnt, rvalid, rerr and o_mem_* outputs to 0, and both rdata outputs to 0.
REQ-020 An in-flight access SHALL be dropped on reset mid-operation, with no response after reset is released.
REQ-021 After reset release, the first grant SHALL be possible on the first rising edge.

Verification
REQ-022 Single fetch: i_if_req=1, addr 0x0000_0010, ack 2 cycles later with rdata 0x0000_0013 -> o_if_gnt in cycle 0, o_mem_req in cycles 1-2, o_if_rvalid=1 with rdata 0x0000_0013 in cycle 3.
REQ-023 Store: ls_we=1, addr 0x7000, wdata 0x0000_00AB, be=4'b0001, ack in cycle 1 -> the o_mem_* outputs mirror the captured values, and o_ls_rvalid=1 with rdata=0 in cycle 2.
REQ-024 Starvation: both requests held continuously with STARVE_MAX=4 and every ack immediate -> grant order LS,LS,LS,LS,IF,LS...
REQ-025 Timeout: TIMEOUT=8 and ack never arrives -> o_mem_req high for 8 cycles, then o_ls_rvalid=1, o_ls_rerr=1, rdata=0; a following request is granted normally.
REQ-026 Back-to-back: a new i_ls_req held during rvalid -> o_ls_gnt is high in the same cycle as o_if_rvalid.
REQ-027 Reset mid-access: i_rst_n pulsed low in BUSY_LS -> all outputs 0 asynchronously, and no rvalid after release even if i_mem_ack arrives.
